// File: rtl/rb_cfg_bank_pkg.sv
// Shared types and address-map helpers for the rb_cfg_bank register bank.
package rb_cfg_bank_pkg;

  localparam int unsigned RSP_DATA_W = 32;
  localparam int unsigned FLAG_OFS   = 0;
  localparam int unsigned COMMIT_OFS = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  // Response payload; rdata is sized for the widest supported DATA_W.
  typedef struct packed {
    logic [RSP_DATA_W-1:0] rdata;
    logic                  err;
  } rsp_t;

  function automatic int unsigned flag_addr(input int unsigned n_regs);
    return n_regs + FLAG_OFS;
  endfunction

  function automatic int unsigned commit_addr(input int unsigned n_regs);
    return n_regs + COMMIT_OFS;
  endfunction

endpackage

// File: rtl/rb_sticky_flags.sv
// Sticky flag register: per-bit set pulses, write-1-to-clear, set beats clear.
module rb_sticky_flags #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] i_set,
  input  logic [DATA_W-1:0] i_clr,
  output logic [DATA_W-1:0] o_flags
);

  logic [DATA_W-1:0] r_flags;

  always_ff @(posedge clk) begin
    if (rst) r_flags <= '0;
    else     r_flags <= (r_flags & ~i_clr) | i_set;
  end

  assign o_flags = r_flags;

endmodule

// File: rtl/rb_cfg_bank.sv
// Bus-accessible configuration register bank with sticky flags.
// Define RB_CFG_SHADOW_EN to stage cfg writes in a shadow copy applied on commit.
module rb_cfg_bank
  import rb_cfg_bank_pkg::*;
#(
  parameter int unsigned                ADDR_W  = 4,
  parameter int unsigned                DATA_W  = 8,
  parameter int unsigned                N_REGS  = 8,
  parameter logic [N_REGS*DATA_W-1:0]   RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [DATA_W-1:0]          req_wdata,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       rsp_err,
  output logic [N_REGS*DATA_W-1:0]   cfg_q,
  input  logic [DATA_W-1:0]          flag_set,
  output logic [DATA_W-1:0]          flag_q,
  input  logic                       commit_i,
  output logic                       cfg_pending
);

  localparam int unsigned IDX_W       = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int unsigned CFG_W       = N_REGS * DATA_W;
  localparam int unsigned FLAG_ADDR   = flag_addr(N_REGS);
  localparam int unsigned COMMIT_ADDR = commit_addr(N_REGS);

  if (N_REGS + 2 > 2**ADDR_W) begin : g_bad_map
    $error("rb_cfg_bank: N_REGS+2 does not fit in ADDR_W address bits");
  end
  if (DATA_W > RSP_DATA_W) begin : g_bad_data_w
    $error("rb_cfg_bank: DATA_W exceeds response payload width");
  end

  state_e              state_q, state_d;
  logic                r_req_ready, r_rsp_valid, r_pending;
  rsp_t                r_rsp, w_rsp;
  logic [CFG_W-1:0]    r_cfg, w_cfg_d, w_cfg_view;
  logic                w_accept, w_wr, w_pending_d;
  logic                w_is_cfg, w_is_flag, w_is_commit;
  logic [IDX_W-1:0]    w_idx;
  logic [DATA_W-1:0]   w_flag_clr, w_flags;
  logic [RSP_DATA_W-1:0] w_unused_rdata;

  // Handshake FSM: accept in IDLE, hold the response in RESP until consumed.
  always_comb begin
    state_d  = state_q;
    w_accept = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          state_d  = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_is_cfg    = (req_addr < ADDR_W'(N_REGS));
  assign w_is_flag   = (req_addr == ADDR_W'(FLAG_ADDR));
  assign w_is_commit = (req_addr == ADDR_W'(COMMIT_ADDR));
  assign w_idx       = IDX_W'(req_addr);
  assign w_wr        = w_accept & req_write;
  assign w_flag_clr  = (w_wr && w_is_flag) ? req_wdata : '0;

  // Response is captured at accept; writes and errors return zero data.
  always_comb begin
    w_rsp = '0;
    if (!w_is_cfg && !w_is_flag && !w_is_commit) begin
      w_rsp.err = 1'b1;
    end else if (!req_write) begin
      if (w_is_cfg)       w_rsp.rdata = RSP_DATA_W'(w_cfg_view[w_idx*DATA_W +: DATA_W]);
      else if (w_is_flag) w_rsp.rdata = RSP_DATA_W'(w_flags);
    end
  end

`ifdef RB_CFG_SHADOW_EN
  logic [CFG_W-1:0] r_shadow, w_shadow_d;

  // A commit in the same cycle as a cfg write picks up the new shadow value.
  always_comb begin
    w_shadow_d = r_shadow;
    if (w_wr && w_is_cfg) w_shadow_d[w_idx*DATA_W +: DATA_W] = req_wdata;
    w_cfg_d = r_cfg;
    if (commit_i || (w_wr && w_is_commit)) w_cfg_d = w_shadow_d;
  end

  always_ff @(posedge clk) begin
    if (rst) r_shadow <= RST_VAL;
    else     r_shadow <= w_shadow_d;
  end

  assign w_pending_d = (w_shadow_d != w_cfg_d);
  assign w_cfg_view  = r_shadow;
`else
  logic w_unused_commit;

  always_comb begin
    w_cfg_d = r_cfg;
    if (w_wr && w_is_cfg) w_cfg_d[w_idx*DATA_W +: DATA_W] = req_wdata;
  end

  assign w_pending_d     = 1'b0;
  assign w_cfg_view      = r_cfg;
  assign w_unused_commit = commit_i;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp       <= '0;
      r_cfg       <= RST_VAL;
      r_pending   <= 1'b0;
    end else begin
      state_q     <= state_d;
      r_req_ready <= (state_d == ST_IDLE);
      r_rsp_valid <= (state_d == ST_RESP);
      if (w_accept) r_rsp <= w_rsp;
      r_cfg       <= w_cfg_d;
      r_pending   <= w_pending_d;
    end
  end

  rb_sticky_flags #(
    .DATA_W (DATA_W)
  ) u_flags (
    .clk     (clk),
    .rst     (rst),
    .i_set   (flag_set),
    .i_clr   (w_flag_clr),
    .o_flags (w_flags)
  );

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rsp.rdata[DATA_W-1:0];
  assign rsp_err        = r_rsp.err;
  assign cfg_q          = r_cfg;
  assign flag_q         = w_flags;
  assign cfg_pending    = r_pending;
  assign w_unused_rdata = r_rsp.rdata;

endmodule
